// File: rtl/soc_irq_pkg.sv
// Shared constants for the interrupt controller: register word offsets,
// the "no source" ID and the STATUS busy bit position.
package soc_irq_pkg;

    localparam logic [4:0] IRQC_PENDING  = 5'h00;
    localparam logic [4:0] IRQC_ENABLE   = 5'h04;
    localparam logic [4:0] IRQC_CLAIM    = 5'h08;
    localparam logic [4:0] IRQC_COMPLETE = 5'h0C;
    localparam logic [4:0] IRQC_TRIGGER  = 5'h10;
    localparam logic [4:0] IRQC_STATUS   = 5'h14;

    localparam int unsigned IRQ_ID_NONE     = 32'd0;
    localparam int unsigned STATUS_BUSY_BIT = 32'd31;

    // Source index i is reported to software as ID i+1 so that 0 can mean "none".
    function automatic int unsigned src_to_id(input int unsigned idx);
        return idx + 32'd1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: returns valid plus the 1-based ID of the
// lowest set request bit.
module irq_prio_enc
    import soc_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan upward and keep only the first hit.
    always_comb begin
        valid = 1'b0;
        id    = ID_W'(IRQ_ID_NONE);
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                id    = ID_W'(src_to_id(i));
            end else begin
                id    = id;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with CLAIM/COMPLETE handshake, non-nesting.
// Optional per-source rising-edge mode is built when IRQC_EDGE_EN is defined.
module irq_ctrl
    import soc_irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    input  logic               re,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               cpu_irq
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q,  enable_d;
    logic               busy_q,    busy_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic               cpu_irq_q, cpu_irq_d;

    logic [4:0]         offset_s;
    logic               enc_valid_s;
    logic [ID_W-1:0]    enc_id_s;
    logic [ID_W-1:0]    claim_id_s;
    logic               claim_fire_s;
    logic               complete_ok_s;
    logic [NUM_SRC-1:0] claim_clr_s;
    logic [NUM_SRC-1:0] level_set_s;
    logic [NUM_SRC-1:0] edge_set_s;
    logic               unused_s;

    assign offset_s = addr[4:0];
    assign unused_s = ^{addr[31:5], wdata[31:NUM_SRC]};

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (pending_q & enable_q),
        .valid (enc_valid_s),
        .id    (enc_id_s)
    );

`ifdef IRQC_EDGE_EN
    logic [NUM_SRC-1:0] trigger_q, trigger_d;
    logic [NUM_SRC-1:0] src_q;

    // Edge-mode storage: trigger select and the previous-cycle copy of the sources.
    always_ff @(posedge clk) begin
        if (reset) begin
            trigger_q <= '0;
            src_q     <= '0;
        end else begin
            trigger_q <= trigger_d;
            src_q     <= irq_src;
        end
    end

    // TRIGGER write and per-source split between level and edge set terms.
    always_comb begin
        trigger_d = trigger_q;
        if (we && (offset_s == IRQC_TRIGGER)) begin
            trigger_d = wdata[NUM_SRC-1:0];
        end else begin
            trigger_d = trigger_q;
        end
        level_set_s = irq_src & ~trigger_q;
        edge_set_s  = irq_src & ~src_q & trigger_q;
    end
`else
    // Without edge support every source is level sensitive.
    always_comb begin
        level_set_s = irq_src;
        edge_set_s  = '0;
    end
`endif

    // Bus decode of the handshake events and the one-hot clear of the claimed bit.
    always_comb begin
        claim_id_s    = ID_W'(IRQ_ID_NONE);
        claim_fire_s  = 1'b0;
        complete_ok_s = 1'b0;
        claim_clr_s   = '0;
        if (!busy_q && enc_valid_s) begin
            claim_id_s = enc_id_s;
        end else begin
            claim_id_s = ID_W'(IRQ_ID_NONE);
        end
        if (re && (offset_s == IRQC_CLAIM) && (claim_id_s != ID_W'(IRQ_ID_NONE))) begin
            claim_fire_s = 1'b1;
            claim_clr_s  = NUM_SRC'(1'b1) << (claim_id_s - ID_W'(1'b1));
        end else begin
            claim_fire_s = 1'b0;
        end
        if (we && (offset_s == IRQC_COMPLETE) && busy_q &&
            (wdata[ID_W-1:0] == active_id_q)) begin
            complete_ok_s = 1'b1;
        end else begin
            complete_ok_s = 1'b0;
        end
    end

    // Next state. Level sets lose to a claim clear; edge sets win so no edge is dropped.
    always_comb begin
        pending_d   = ((pending_q | level_set_s) & ~claim_clr_s) | edge_set_s;
        enable_d    = enable_q;
        busy_d      = busy_q;
        active_id_d = active_id_q;
        cpu_irq_d   = enc_valid_s & ~busy_q;
        if (we && (offset_s == IRQC_ENABLE)) begin
            enable_d = wdata[NUM_SRC-1:0];
        end else begin
            enable_d = enable_q;
        end
        if (claim_fire_s) begin
            busy_d      = 1'b1;
            active_id_d = claim_id_s;
        end else if (complete_ok_s) begin
            busy_d      = 1'b0;
            active_id_d = ID_W'(IRQ_ID_NONE);
        end else begin
            busy_d      = busy_q;
            active_id_d = active_id_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            enable_q    <= '0;
            busy_q      <= 1'b0;
            active_id_q <= '0;
            cpu_irq_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            active_id_q <= active_id_d;
            cpu_irq_q   <= cpu_irq_d;
        end
    end

    assign cpu_irq = cpu_irq_q;

    // Combinational read mux; CLAIM shows the ID its side effect would take this cycle.
    always_comb begin
        rdata = 32'd0;
        case (offset_s)
            IRQC_PENDING: rdata = 32'(pending_q);
            IRQC_ENABLE:  rdata = 32'(enable_q);
            IRQC_CLAIM:   rdata = 32'(claim_id_s);
`ifdef IRQC_EDGE_EN
            IRQC_TRIGGER: rdata = 32'(trigger_q);
`endif
            IRQC_STATUS: begin
                rdata                  = 32'(active_id_q);
                rdata[STATUS_BUSY_BIT] = busy_q;
            end
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized self-checking bench for irq_ctrl against a bit-array reference model;
// follows IRQC_EDGE_EN the same way the design does.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, re;
    logic [7:0]  irq_src;
    logic        cpu_irq;

    int total = 0;
    int bad   = 0;

    irq_ctrl #(.NUM_SRC(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .irq_src (irq_src),
        .cpu_irq (cpu_irq)
    );

    always #5 clk = ~clk;

    // Reference model state, one entry per source.
    bit m_pend [8];
    bit m_en   [8];
    bit m_trig [8];
    bit m_prev [8];
    bit m_busy;
    int m_act;
    bit m_cpu;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int m_winner();
        if (m_busy) return 0;
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) return i + 1;
        return 0;
    endfunction

    function automatic logic [31:0] m_bits(input bit v [8]);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = r + (32'd1 << i);
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[4:0])
            5'h00: return m_bits(m_pend);
            5'h04: return m_bits(m_en);
            5'h08: return 32'(m_winner());
`ifdef IRQC_EDGE_EN
            5'h10: return m_bits(m_trig);
`endif
            5'h14: return (m_busy ? 32'h8000_0000 : 32'd0) + 32'(m_act);
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(input bit rst_v, we_v, re_v, input logic [31:0] a, d, input logic [7:0] s);
        int win = m_winner();
        bit any = 1'b0;
        for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) any = 1'b1;
        if (rst_v) begin
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_trig[i] = 0; m_prev[i] = 0;
            end
            m_busy = 0; m_act = 0; m_cpu = 0;
            return;
        end
        m_cpu = any && !m_busy;
        for (int i = 0; i < 8; i++) begin
            bit clr = re_v && a[4:0] == 5'h08 && win == i + 1;
            if (m_trig[i]) m_pend[i] = (m_pend[i] && !clr) || (s[i] && !m_prev[i]);
            else           m_pend[i] = (m_pend[i] || s[i]) && !clr;
        end
        if (re_v && a[4:0] == 5'h08 && win != 0) begin
            m_busy = 1; m_act = win;
        end else if (we_v && a[4:0] == 5'h0C && m_busy && int'(d[3:0]) == m_act) begin
            m_busy = 0; m_act = 0;
        end
        for (int i = 0; i < 8; i++) begin
            if (we_v && a[4:0] == 5'h04) m_en[i] = d[i];
`ifdef IRQC_EDGE_EN
            if (we_v && a[4:0] == 5'h10) m_trig[i] = d[i];
`endif
            m_prev[i] = s[i];
        end
    endtask

    // One bus cycle: drive on the falling edge, check rdata, clock, check cpu_irq.
    task automatic cycle(input bit rst_v, we_v, re_v, input logic [31:0] a, d,
                         input logic [7:0] s, output logic [31:0] v);
        @(negedge clk);
        reset = rst_v; we = we_v; re = re_v; addr = a; wdata = d; irq_src = s;
        #1;
        check($sformatf("rdata@%02h", a[4:0]), rdata, m_read(a));
        v = rdata;
        m_step(rst_v, we_v, re_v, a, d, s);
        @(posedge clk);
        #1;
        check("cpu_irq", {31'd0, cpu_irq}, {31'd0, m_cpu});
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] s, output logic [31:0] v);
        cycle(1'b0, 1'b0, 1'b1, a, 32'd0, s, v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
        logic [31:0] v;
        cycle(1'b0, 1'b1, 1'b0, a, d, s, v);
    endtask

    task automatic idle(input logic [7:0] s);
        logic [31:0] v;
        cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, s, v);
    endtask

    task automatic rst_cyc(input logic [7:0] s);
        logic [31:0] v;
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, s, v);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0; irq_src = 8'd0;
        m_step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'd0);
        repeat (2) @(posedge clk);

        // Reset state
        rst_cyc(8'h00);
        rd(32'h00, 8'h00, v); check("rst_pending", v, 32'd0);
        rd(32'h04, 8'h00, v); check("rst_enable", v, 32'd0);
        rd(32'h14, 8'h00, v); check("rst_status", v, 32'd0);
        check("rst_cpu", {31'd0, cpu_irq}, 32'd0);

        // 1: single pulse on the timer source
        wr(32'h04, 32'h01, 8'h00);
        idle(8'h01);
        rd(32'h00, 8'h00, v); check("t1_pending", v, 32'h01);
        check("t1_cpu_on", {31'd0, cpu_irq}, 32'd1);
        rd(32'h08, 8'h00, v); check("t1_claim", v, 32'd1);
        rd(32'h00, 8'h00, v); check("t1_pending_clr", v, 32'd0);
        check("t1_cpu_off", {31'd0, cpu_irq}, 32'd0);
        wr(32'h0C, 32'd1, 8'h00);

        // 2: priority and non-nesting
        wr(32'h04, 32'hFF, 8'h0A);
        rd(32'h08, 8'h0A, v); check("t2_claim", v, 32'd2);
        rd(32'h08, 8'h08, v); check("t2_claim_busy", v, 32'd0);
        check("t2_cpu_busy", {31'd0, cpu_irq}, 32'd0);

        // 3: COMPLETE with wrong then right ID
        wr(32'h0C, 32'd5, 8'h08);
        rd(32'h14, 8'h08, v); check("t3_status_busy", v, 32'h8000_0002);
        wr(32'h0C, 32'd2, 8'h08);
        rd(32'h14, 8'h08, v); check("t3_status_idle", v, 32'd0);
        rd(32'h08, 8'h08, v); check("t2_claim_next", v, 32'd4);
        wr(32'h0C, 32'd4, 8'h00);

        // 4: disabled sources still latch
        wr(32'h04, 32'h00, 8'h04);
        idle(8'h04);
        rd(32'h00, 8'h04, v); check("t4_pending", v, 32'h04);
        check("t4_cpu_masked", {31'd0, cpu_irq}, 32'd0);
        rd(32'h08, 8'h04, v); check("t4_claim_masked", v, 32'd0);
        wr(32'h04, 32'h04, 8'h04);
        idle(8'h04);
        check("t4_cpu_unmasked", {31'd0, cpu_irq}, 32'd1);
        rd(32'h08, 8'h00, v); check("t4_claim", v, 32'd3);
        wr(32'h0C, 32'd3, 8'h00);

        // 5: reset while in service
        wr(32'h04, 32'h01, 8'h07);
        idle(8'h00);
        rd(32'h08, 8'h00, v); check("t5_claim", v, 32'd1);
        rd(32'h00, 8'h00, v); check("t5_pending", v, 32'h06);
        rst_cyc(8'h00);
        check("t5_cpu", {31'd0, cpu_irq}, 32'd0);
        rd(32'h00, 8'h00, v); check("t5_pending_rst", v, 32'd0);
        rd(32'h04, 8'h00, v); check("t5_enable_rst", v, 32'd0);
        rd(32'h14, 8'h00, v); check("t5_status_rst", v, 32'd0);

`ifdef IRQC_EDGE_EN
        // 6: rising-edge mode
        wr(32'h10, 32'h01, 8'h00);
        rd(32'h10, 8'h00, v); check("t6_trigger", v, 32'h01);
        wr(32'h04, 32'h01, 8'h00);
        idle(8'h01);
        idle(8'h01);
        rd(32'h08, 8'h01, v); check("t6_claim", v, 32'd1);
        wr(32'h0C, 32'd1, 8'h01);
        idle(8'h01);
        rd(32'h00, 8'h01, v); check("t6_held_once", v, 32'd0);
        idle(8'h00);
        idle(8'h01);
        idle(8'h00);
        rd(32'h08, 8'h01, v); check("t6_claim_edge", v, 32'd1);
        rd(32'h00, 8'h00, v); check("t6_edge_wins", v, 32'h01);
        wr(32'h0C, 32'd1, 8'h00);
`else
        wr(32'h10, 32'hFF, 8'h00);
        rd(32'h10, 8'h00, v); check("t6_no_trigger", v, 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            logic [7:0]  s = 8'($urandom & $urandom & $urandom);
            logic [31:0] d = $urandom;
            int op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: rd(32'h08, s, v);
                3: wr(32'h0C, ($urandom_range(0, 3) != 0) ? 32'(m_act) : 32'($urandom_range(0, 9)), s);
                4: wr(32'h04, d, s);
                5: wr(32'h10, d, s);
                6: rd(32'($urandom_range(0, 7) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0)), s, v);
                7: wr(32'($urandom_range(0, 7) * 4), d, s);
                8: idle(s);
                default: begin
                    if ($urandom_range(0, 19) == 0) rst_cyc(s);
                    else idle(s);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
